// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/data/ctrl latch with stall, flush and stall/bubble counters.
// Latency: 1 cycle from in_* to out_*; all outputs are registered.
// Backpressure: stall holds the contents; flush loads a bubble, or is deferred while stalled when FLUSH_PRIO=0.
module pipe_stage_reg #(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 8,
  parameter int CNT_W      = 16,
  parameter int FLUSH_PRIO = 1,
  parameter int CLEAR_DATA = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              clear_counts,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              flush_pending,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  bubble_count
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic              eflush;
  logic              bubble_loaded;

  // Increment computed one bit wider; the carry-out means the counter is already at max.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    sat_inc = sum[CNT_W] ? cnt : sum[CNT_W-1:0];
  endfunction

  // A flush request is either live this cycle or remembered from an earlier stalled cycle.
  assign eflush = flush | pend_q;

  // Next-state selection: priority flush, then stall/hold, then deferred flush, then normal load.
  always_comb begin
    valid_d       = valid_q;
    data_d        = data_q;
    ctrl_d        = ctrl_q;
    pend_d        = pend_q;
    bubble_loaded = 1'b0;
    if ((FLUSH_PRIO != 0) && eflush) begin
      valid_d       = 1'b0;
      ctrl_d        = '0;
      data_d        = (CLEAR_DATA != 0) ? '0 : data_q;
      bubble_loaded = 1'b1;
    end else if (stall) begin
      if ((FLUSH_PRIO == 0) && flush) begin
        pend_d = 1'b1;
      end
    end else if (eflush) begin
      valid_d       = 1'b0;
      ctrl_d        = '0;
      data_d        = (CLEAR_DATA != 0) ? '0 : data_q;
      pend_d        = 1'b0;
      bubble_loaded = 1'b1;
    end else begin
      valid_d       = in_valid;
      data_d        = in_data;
      ctrl_d        = in_valid ? in_ctrl : '0;
      bubble_loaded = ~in_valid;
    end
    // With flush priority the deferral path never exists.
    if (FLUSH_PRIO != 0) begin
      pend_d = 1'b0;
    end
  end

  // Counter next-state: clear wins over any increment on the same edge.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (clear_counts) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (stall) begin
        stall_cnt_d = sat_inc(stall_cnt_q);
      end
      if (bubble_loaded) begin
        bubble_cnt_d = sat_inc(bubble_cnt_q);
      end
    end
  end

  // State registers; reset clears everything immediately, including a pending flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      ctrl_q       <= '0;
      pend_q       <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      ctrl_q       <= ctrl_d;
      pend_q       <= pend_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_data      = data_q;
  assign out_ctrl      = ctrl_q;
  assign flush_pending = pend_q;
  assign stall_count   = stall_cnt_q;
  assign bubble_count  = bubble_cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the CPU datapath. It generalises the fixed-field stage latches into a single block with configurable data and control widths. It adds a valid bit, stall (hold), flush (bubble insertion) with selectable priority and a deferred-flush mode, and saturating stall/bubble performance counters. It is instantiated between adjacent pipeline stages, for example EX→MEM.

## Interface
- DATA_W, default 64: width of the payload bus. Operands, results and addresses are packed here.
- CTRL_W, default 8: width of the control bus. Write enables, mem read/write and register destination go here. It is forced to zero on every bubble.
- CNT_W, default 16: width of each performance counter.
- FLUSH_PRIO, default 1: 1 means flush overrides stall. 0 means stall wins and the flush is deferred.
- CLEAR_DATA, default 0: 1 means out_data is zeroed on a bubble. 0 means out_data holds its previous value.

Ports:
- clock  in  1  Single clock, rising edge.
- reset  in  1  Asynchronous, active-high reset.
- stall  in  1  Hold the current contents this cycle.
- flush  in  1  Squash: load a bubble instead of the input.
- in_valid  in  1  The input instruction is valid.
- in_data  in  DATA_W  Payload from the upstream stage.
- in_ctrl  in  CTRL_W  Control bits from the upstream stage.
- clear_counts  in  1  Synchronous clear of both counters.
- out_valid  out  1  The registered instruction is valid.
- out_data  out  DATA_W  Registered payload.
- out_ctrl  out  CTRL_W  Registered control. It is all zeros whenever out_valid=0.
- flush_pending  out  1  A deferred flush is waiting (FLUSH_PRIO=0 only).
- stall_count  out  CNT_W  Saturating count of stalled cycles.
- bubble_count  out  CNT_W  Saturating count of bubbles loaded.

## Operation
- Reset values: out_valid=0, out_data=0, out_ctrl=0, flush_pending=0, stall_count=0, bubble_count=0.
- Effective flush is eflush = flush | flush_pending.
- Per-edge action, highest priority first:
  - FLUSH_PRIO=1 and eflush: load a bubble. Any stall is ignored.
  - stall: hold all outputs. If FLUSH_PRIO=0 and flush=1, set flush_pending=1.
  - eflush, which is only reachable with FLUSH_PRIO=0: load a bubble and clear flush_pending.
  - Otherwise load: out_valid<=in_valid, out_data<=in_data, out_ctrl<=in_valid ? in_ctrl : 0.
- Loading a bubble sets out_valid<=0 and out_ctrl<=0. out_data<=0 if CLEAR_DATA=1, otherwise it holds.
- With FLUSH_PRIO=1, flush_pending is tied to 0.
- stall_count increments on every edge with stall=1. This holds even when a FLUSH_PRIO=1 flush overrides the stall.
- bubble_count increments on every edge that loads out_valid=0. That covers an explicit or pending flush, or a normal load with in_valid=0. A held bubble during a stall does not count.
- Counters saturate at 2^CNT_W−1 and never wrap.
- clear_counts=1 zeroes both counters on the edge. It overrides any increment on that same edge.
- The counters are unsigned. Increments are computed at CNT_W+1 bits and then clamped.

## Timing
- Latency is 1 cycle from input to output on a normal load. There is no combinational path from input to output.
- stall, flush and clear_counts are sampled on the rising edge of clock. Their effect is visible after that edge.
- Deferred flush (FLUSH_PRIO=0): the bubble appears on the first edge with stall=0 after the flush request, however long the stall lasts.
  - Multiple flush pulses during a stall collapse into one bubble.
  - If flush=1 and stall=0 on the clearing edge, that produces the same single bubble.
- reset asserted mid-operation clears all state immediately, without waiting for the clock. This includes a pending flush.
- The first active edge after reset deassertion performs a normal action.
- Simultaneous stall, flush and in_valid with FLUSH_PRIO=1 gives: a bubble, stall_count+1, bubble_count+1.

## Test plan
- Reset then stream: assert reset; all outputs are 0. Deassert reset. Drive in_valid=1, in_data=0x1234, in_ctrl=0x5A. After the next edge: out_valid=1, out_data=0x1234, out_ctrl=0x5A.
- Stall hold: with 0x1234/0x5A loaded, stall for 3 cycles while in_data changes. Required response: the outputs stay unchanged, stall_count=3, bubble_count=0.
- Flush priority: FLUSH_PRIO=1, stall=1 and flush=1 on the same edge. Required response: out_valid=0, out_ctrl=0x00, out_data unchanged (CLEAR_DATA=0), stall_count+1, bubble_count+1.
- Deferred flush: FLUSH_PRIO=0, stall held 4 cycles with flush pulsed on cycles 1 and 3. Required response: flush_pending=1 from the cycle-1 edge, outputs held through the stall. On the first unstalled edge there is exactly one bubble and flush_pending=0. The edge after that loads the input normally.
- Counter saturation and clear: CNT_W=4, hold stall for 20 cycles. stall_count must reach 15 and stay there. Pulse clear_counts together with stall. Required response: stall_count=0 on that edge.
- Async reset mid-stream: assert reset between edges while flush_pending=1 and out_valid=1. Required response: outputs return to their reset values before the next clock edge, and no bubble is inserted after release.
